sar_result_fifo: RTL
====================

# sar_result_fifo

Downstream stage of the SAR conversion logic in the time-domain SAR ADC. It captures the 7-bit conversion code on each end-of-conversion event and optionally averages 2^AVG_LOG2 consecutive codes. Each result is pushed into a small synchronous FIFO, and results leave through a valid/ready stream toward the digital back end. It also reports fill level and a sticky overflow flag.

## Interface
Parameters:
- AVG_LOG2, default 0: log2 of the number of codes averaged per output word. Legal range is 0..4.
- DEPTH, default 8: FIFO depth in words. Must be a power of two, 2..64.

Ports:
- clk  in  1  conversion clock, the same clock that drives the SAR logic. Rising edge only.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  block enable. Low means synchronous flush.
- eoc  in  1  end-of-conversion from the SAR logic, synchronous to clk. May stay high for one or more cycles.
- din  in  7  conversion code. Valid while eoc is high.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- m_valid  out  1  output word available.
- m_data  out  7  output word (average or raw code).
- m_ready  in  1  downstream accept.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- ovf  out  1  sticky overflow flag.

## Operation
- Capture strobe: `stb = eoc & ~eoc_q`, where eoc_q is eoc registered.
  - Exactly one capture per eoc high period.
  - din is sampled in the strobe cycle.
- Accumulator:
  - acc is 7+AVG_LOG2 bits wide; cnt is AVG_LOG2 bits wide.
  - On stb: acc += din and cnt += 1.
  - When cnt wraps (the last sample of a group), the word pushed is (acc + din) >> AVG_LOG2, truncated, not rounded. acc is then set to 0 in the same cycle.
  - AVG_LOG2=0: every strobe pushes din unchanged.
- FIFO:
  - First-word-fall-through. m_data is valid whenever m_valid=1.
  - Pop occurs when m_valid & m_ready.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the word is dropped and ovf is set. FIFO contents are unchanged.
- ovf clearing:
  - ovf clears on clr_ovf.
  - If clr_ovf and an overflow occur in the same cycle, set wins.
- Simultaneous push and pop when empty: the push is accepted. m_valid rises the next cycle. There is no bypass.
- en=0:
  - Each cycle, flush the FIFO (fill=0, m_valid=0) and clear acc, cnt and eoc_q.
  - No captures occur.
  - ovf is held.
- en rising while eoc is already high: that eoc high period is not captured (eoc_q was cleared to 0, so the strobe would fire). To prevent this, eoc_q is instead loaded with eoc during en=0.
- Reset values: m_valid=0, m_data=0, fill=0, ovf=0, acc=0, cnt=0, eoc_q=0, read and write pointers 0.
- Reset mid-conversion: a partial average is discarded and no word is pushed.

## Timing
- Strobe at cycle k: the push is registered at the edge ending cycle k.
  - m_valid=1 and fill updated in cycle k+1 if the FIFO was empty.
  - Capture-to-output latency is 1 cycle after the final sample of a group.
- Pop: the handshake at the edge ending cycle j advances the read pointer. The next word (or m_valid=0) appears in cycle j+1.
- fill reflects the registered state: +1 on push only, −1 on pop only, unchanged on push+pop.
- Throughput: one push per cycle maximum. Actual eoc rate is at most one per 8 SAR cycles.
- Pointers are $clog2(DEPTH)+1 bits; full and empty are decided by comparing the MSB and the remaining bits. Wrap-around at DEPTH is natural binary.
- No combinational path from m_ready to m_valid or m_data.

## Structure
- Shared package sar_adc_pkg holds:
  - CODE_W=7.
  - The code_t typedef (logic [CODE_W-1:0]).
  - MAX_AVG_LOG2=4.
- Sub-module sar_code_fifo is the generic synchronous FWFT FIFO. It has ports clk, rst_n, flush, push, wdata, pop, rdata, empty, full and fill.
- The top level contains the edge detector, the accumulator/decimator and the ovf logic.
- Parameter checks are elaboration-time assertions.

## Test plan
- AVG_LOG2=0, DEPTH=8: eoc pulses with din=0x15, 0x7F, 0x00, and m_ready=1 → m_data 0x15, 0x7F, 0x00 in order, each 1 cycle after its strobe. fill never exceeds 1.
- eoc held high for 5 cycles with din=0x2A → exactly one word 0x2A is pushed.
- AVG_LOG2=2: codes 10, 11, 12, 14 → one word 11 (47>>2, truncated) is pushed 1 cycle after the 4th strobe, with no output before it.
- m_ready=0 with 9 strobes into DEPTH=8 → fill=8, ovf=1, and the 9th code is lost. Then m_ready=1 → the first 8 codes are read in order. clr_ovf → ovf=0.
- FIFO full with push and pop in the same cycle → no ovf and fill stays at 8. Also clr_ovf coincident with an overflow → ovf=1.
- Disturbances: en=0 mid-group (AVG_LOG2=2, after 2 strobes) and rst_n asserted with 3 words queued.
  - After en returns, the next 4 codes form a clean average.
  - The reset asynchronously drives m_valid=0 and fill=0, and ovf=0.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and limits for the SAR ADC digital path.
package sar_adc_pkg;
  localparam int CODE_W       = 7;
  localparam int MAX_AVG_LOG2 = 4;

  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/sar_code_fifo.sv
// Synchronous first-word-fall-through FIFO for conversion codes.
module sar_code_fifo
  import sar_adc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  code_t                    wdata,
  input  logic                     pop,
  output code_t                    rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sar_code_fifo: DEPTH must be a power of two in 2..64");
  end

  logic [AW:0] r_wptr, r_rptr;
  code_t       r_mem [DEPTH];
  logic        w_wr, w_rd;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign fill  = r_wptr - r_rptr;

  // A pop frees the slot this same edge, so a push into a full FIFO is still accepted.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  assign rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/sar_result_fifo.sv
// EOC edge capture, optional 2^AVG_LOG2 averaging, result FIFO and sticky overflow.
module sar_result_fifo
  import sar_adc_pkg::*;
#(
  parameter int AVG_LOG2 = 0,
  parameter int DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         eoc,
  input  code_t                        din,
  input  logic                         clr_ovf,
  output logic                         m_valid,
  output code_t                        m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         ovf
);
  if (AVG_LOG2 < 0 || AVG_LOG2 > MAX_AVG_LOG2) begin : g_bad_avg
    $error("sar_result_fifo: AVG_LOG2 must be in 0..4");
  end

  logic  r_eoc_q, r_ovf;
  logic  w_stb, w_push, w_pop, w_empty, w_full;
  code_t w_word;

  // While disabled eoc_q tracks eoc, so an eoc already high at enable is not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_eoc_q <= 1'b0;
    else        r_eoc_q <= eoc;
  end

  assign w_stb = en & eoc & ~r_eoc_q;

  if (AVG_LOG2 == 0) begin : g_raw
    assign w_push = w_stb;
    assign w_word = din;
  end else begin : g_avg
    logic [CODE_W+AVG_LOG2-1:0] r_acc, w_sum;
    logic [AVG_LOG2-1:0]        r_cnt;
    logic                       w_last;

    assign w_sum  = r_acc + {{AVG_LOG2{1'b0}}, din};
    assign w_last = &r_cnt;
    assign w_push = w_stb & w_last;
    assign w_word = w_sum[AVG_LOG2 +: CODE_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (!en) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_stb) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_last ? '0 : w_sum;
      end
    end
  end

  assign m_valid = ~w_empty;
  assign w_pop   = m_valid & m_ready;

  sar_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (~en),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (m_data),
    .empty (w_empty),
    .full  (w_full),
    .fill  (fill)
  );

  // Set beats clear when both land in the same cycle; flag is frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (en) begin
      if (w_push && w_full && !w_pop)    r_ovf <= 1'b1;
      else if (clr_ovf)                  r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
endmodule
